// File: rtl/adsr_pkg.sv
// Shared types and helpers for the ADSR envelope generator.
// State encodings are visible on the stage debug port, so keep them stable.
package adsr_pkg;

    localparam int DEF_TOTAL_BITS      = 16;
    localparam int DEF_FRACTIONAL_BITS = 15;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ATTACK  = 3'd1,
        ST_DECAY   = 3'd2,
        ST_SUSTAIN = 3'd3,
        ST_RELEASE = 3'd4
    } env_state_t;

    typedef logic [DEF_TOTAL_BITS-1:0] level_t;

    // Unity gain in the unsigned fixed-point format.
    function automatic logic [31:0] one_const(input int frac_bits);
        return 32'(1) << frac_bits;
    endfunction

endpackage

// File: rtl/adsr_envelope_env_step.sv
// Combinational saturating step: moves level by rate towards limit without overshoot.
// A zero rate means "jump straight to the limit".
module env_step #(
    parameter int TOTAL_BITS = 16
) (
    input  logic [TOTAL_BITS-1:0] level_i,
    input  logic [TOTAL_BITS-1:0] rate_i,
    input  logic [TOTAL_BITS-1:0] limit_i,
    input  logic                  down_i,
    output logic [TOTAL_BITS-1:0] next_o,
    output logic                  reached_o
);

    logic [TOTAL_BITS:0] sum;
    logic [TOTAL_BITS:0] diff;

    always_comb begin
        sum       = {1'b0, level_i} + {1'b0, rate_i};
        diff      = {1'b0, level_i} - {1'b0, rate_i};
        next_o    = level_i;
        reached_o = 1'b0;
        if (rate_i == '0) begin
            next_o    = limit_i;
            reached_o = 1'b1;
        end else if (!down_i) begin
            if (sum >= {1'b0, limit_i}) begin
                next_o    = limit_i;
                reached_o = 1'b1;
            end else begin
                next_o = sum[TOTAL_BITS-1:0];
            end
        end else begin
            // Borrow out of the wide subtract means we passed below zero.
            if (diff[TOTAL_BITS] || (diff[TOTAL_BITS-1:0] <= limit_i)) begin
                next_o    = limit_i;
                reached_o = 1'b1;
            end else begin
                next_o = diff[TOTAL_BITS-1:0];
            end
        end
    end

endmodule

// File: rtl/adsr_envelope.sv
// Per-voice ADSR envelope, one step per sample strobe, gain output in [0, ONE].
// Define ADSR_EXP_RELEASE_EN for geometric release through the shared mul block.
module adsr_envelope
    import adsr_pkg::*;
#(
    parameter int TOTAL_BITS      = 16,
    parameter int FRACTIONAL_BITS = 15
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  sample_en,
    input  logic                  gate,
    input  logic [TOTAL_BITS-1:0] attack_rate,
    input  logic [TOTAL_BITS-1:0] decay_rate,
    input  logic [TOTAL_BITS-1:0] sustain_level,
    input  logic [TOTAL_BITS-1:0] release_rate,
    output logic [TOTAL_BITS-1:0] level,
    output logic                  active,
    output logic [2:0]            stage
);

    localparam logic [TOTAL_BITS-1:0] ONE = TOTAL_BITS'(one_const(FRACTIONAL_BITS));

    env_state_t            state_q;
    logic [TOTAL_BITS-1:0] level_q;
    logic                  active_q;
    logic                  gate_q;
    logic                  pend_q;

    logic [TOTAL_BITS-1:0] sus_eff;
    logic                  pend_eff;
    logic                  release_go;
    logic [TOTAL_BITS-1:0] step_rate;
    logic [TOTAL_BITS-1:0] step_limit;
    logic                  step_down;
    logic [TOTAL_BITS-1:0] step_next;
    logic                  step_reached;
    logic [TOTAL_BITS-1:0] rel_next;
    logic                  rel_done;

    assign sus_eff = (sustain_level > ONE) ? ONE : sustain_level;

    // A rise then fall between strobes collapses to the gate value seen at the strobe.
    assign pend_eff   = gate & (pend_q | ~gate_q);
    assign release_go = !pend_eff &&
                        ((state_q == ST_RELEASE) ||
                         (!gate && (state_q == ST_ATTACK || state_q == ST_DECAY ||
                                    state_q == ST_SUSTAIN)));

    always_comb begin
        step_rate  = attack_rate;
        step_limit = ONE;
        step_down  = 1'b0;
        if (pend_eff) begin
            step_rate  = attack_rate;
            step_limit = ONE;
            step_down  = 1'b0;
        end else if (release_go) begin
            step_rate  = release_rate;
            step_limit = '0;
            step_down  = 1'b1;
        end else if (state_q == ST_DECAY) begin
            step_rate  = decay_rate;
            step_limit = sus_eff;
            step_down  = 1'b1;
        end
    end

    env_step #(.TOTAL_BITS(TOTAL_BITS)) u_step (
        .level_i   (level_q),
        .rate_i    (step_rate),
        .limit_i   (step_limit),
        .down_i    (step_down),
        .next_o    (step_next),
        .reached_o (step_reached)
    );

`ifdef ADSR_EXP_RELEASE_EN
    logic [TOTAL_BITS-1:0] mul_out;

    mul #(
        .TOTAL_BITS      (TOTAL_BITS),
        .FRACTIONAL_BITS (FRACTIONAL_BITS)
    ) u_rel_mul (
        .in1 (level_q),
        .in2 (release_rate),
        .out (mul_out)
    );

    // Coefficients at or above unity would never decay; treat them as instant release.
    assign rel_next = (release_rate >= ONE) ? '0 : mul_out;
    assign rel_done = (rel_next == '0);
`else
    assign rel_next = step_next;
    assign rel_done = step_reached;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            level_q  <= '0;
            active_q <= 1'b0;
            gate_q   <= 1'b0;
            pend_q   <= 1'b0;
        end else begin
            gate_q <= gate;
            if (sample_en) begin
                pend_q <= 1'b0;
                if (pend_eff) begin
                    level_q  <= step_next;
                    state_q  <= step_reached ? ST_DECAY : ST_ATTACK;
                    active_q <= 1'b1;
                end else if (release_go) begin
                    level_q  <= rel_next;
                    state_q  <= rel_done ? ST_IDLE : ST_RELEASE;
                    active_q <= !rel_done;
                end else begin
                    case (state_q)
                        ST_ATTACK: begin
                            level_q <= step_next;
                            if (step_reached) state_q <= ST_DECAY;
                        end
                        ST_DECAY: begin
                            level_q <= step_next;
                            if (step_reached) state_q <= ST_SUSTAIN;
                        end
                        ST_SUSTAIN: level_q <= sus_eff;
                        default: begin
                            state_q  <= ST_IDLE;
                            level_q  <= '0;
                            active_q <= 1'b0;
                        end
                    endcase
                end
            end else if (gate && !gate_q) begin
                pend_q <= 1'b1;
            end
        end
    end

    assign level  = level_q;
    assign active = active_q;
    assign stage  = state_q;

endmodule
